// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_LOG = 2'b00,
        SH_ARI = 2'b01,
        SH_ROT = 2'b10,
        SH_RSV = 2'b11
    } shift_mode_e;

    // Upper bound on the shift-amount field carried in the ctrl struct.
    localparam int unsigned MaxShw = 16;

    typedef struct packed {
        logic              dir;
        shift_mode_e       mode;
        logic [MaxShw-1:0] amt;
    } stage_ctrl_t;

    function automatic bit is_pow2(input int unsigned v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter level: conditional shift by DIST and the OR of bits pushed off the end.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIST  = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             dir,
    input  shift_mode_e      mode,
    output logic [WIDTH-1:0] dout,
    output logic             lost
);

    logic [DIST-1:0] fill;

    always_comb begin
        fill = {DIST{(mode == SH_ARI) & din[WIDTH-1]}};
        dout = din;
        lost = 1'b0;
        if (en) begin
            if (mode == SH_ROT) begin
                if (dir) begin
                    dout = {din[DIST-1:0], din[WIDTH-1:DIST]};
                end else begin
                    dout = {din[WIDTH-DIST-1:0], din[WIDTH-1:WIDTH-DIST]};
                end
            end else if (dir) begin
                // Sign fill only for arithmetic; reserved falls through as logical.
                dout = {fill, din[WIDTH-1:DIST]};
                lost = |din[DIST-1:0];
            end else begin
                dout = {din[WIDTH-DIST-1:0], {DIST{1'b0}}};
                lost = |din[WIDTH-1:WIDTH-DIST];
            end
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined WIDTH-bit barrel shifter with a valid/ready stream interface and a global stall.
module barrel_shifter_pipe
    import shifter_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shift_amt,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             lost_out,
    output logic             busy
);

    localparam bit WidthOk = is_pow2(WIDTH) && (SHW <= MaxShw);

    if (!WidthOk) begin : g_bad_width
        $error("barrel_shifter_pipe: WIDTH must be a power of 2, at least 2");
    end

    logic              adv;
    stage_ctrl_t       in_ctrl;

    logic [SHW-1:0]    vld_q, vld_d;
    logic [SHW-1:0]    lost_q, lost_d;
    logic [WIDTH-1:0]  data_q [SHW];
    logic [WIDTH-1:0]  data_d [SHW];
    stage_ctrl_t       ctrl_q [SHW];
    stage_ctrl_t       ctrl_d [SHW];
    logic [SHW-1:0]    unused_parity;
    logic              unused_ctrl;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    always_comb begin
        in_ctrl                = '0;
        in_ctrl.dir            = dir;
        in_ctrl.mode           = shift_mode_e'(mode);
        in_ctrl.amt[SHW-1:0]   = shift_amt;
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        logic [WIDTH-1:0] s_din;
        logic [WIDTH-1:0] s_dout;
        stage_ctrl_t      s_ctrl;
        logic             s_vld;
        logic             s_lost_in;
        logic             s_lost;

        if (k == 0) begin : g_first
            assign s_din     = data_in;
            assign s_ctrl    = in_ctrl;
            assign s_vld     = in_valid;
            assign s_lost_in = 1'b0;
        end else begin : g_next
            assign s_din     = data_q[k-1];
            assign s_ctrl    = ctrl_q[k-1];
            assign s_vld     = vld_q[k-1];
            assign s_lost_in = lost_q[k-1];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .din  (s_din),
            .en   (s_ctrl.amt[k]),
            .dir  (s_ctrl.dir),
            .mode (s_ctrl.mode),
            .dout (s_dout),
            .lost (s_lost)
        );

        assign data_d[k] = s_dout;
        assign ctrl_d[k] = s_ctrl;
        assign vld_d[k]  = s_vld;
        assign lost_d[k] = s_lost_in | s_lost;

        // The last ctrl copy and the padding bits of amt feed nothing downstream.
        assign unused_parity[k] = ^ctrl_q[k];
    end

    assign unused_ctrl = ^unused_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            lost_q <= '0;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
                ctrl_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q  <= vld_d;
            lost_q <= lost_d;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= data_d[k];
                ctrl_q[k] <= ctrl_d[k];
            end
        end
    end

    assign out_valid = vld_q[SHW-1];
    assign data_out  = data_q[SHW-1];
    assign lost_out  = lost_q[SHW-1];
    assign busy      = |vld_q;

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
Parametrised, pipelined barrel shifter with a valid/ready stream interface. It replaces the fixed 4-bit combinational shifter with a WIDTH-bit unit. It supports logical shift, arithmetic shift and rotate in both directions, and reports whether any set bits were shifted out. It is used as a reusable datapath element wherever a shifted operand is needed under backpressure.

Parameters:
WIDTH, 8, data width in bits; must be a power of 2 and at least 2.
SHW, $clog2(WIDTH), shift-amount width and number of pipeline stages; derived, not overridden.

Ports:
clk        input   1      system clock, rising edge
rst_n      input   1      asynchronous active-low reset
in_valid   input   1      input beat valid
in_ready   output  1      block can accept a beat this cycle
data_in    input   WIDTH  operand
shift_amt  input   SHW    shift distance, 0..WIDTH-1
dir        input   1      0 = left, 1 = right
mode       input   2      00 logical, 01 arithmetic, 10 rotate, 11 reserved
out_valid  output  1      result beat valid
out_ready  input   1      downstream accepts the result
data_out   output  WIDTH  shifted result
lost_out   output  1      1 if any 1-bit was shifted off the end; always 0 for rotate
busy       output  1      OR of all stage valid flags

Behaviour:
- One clock. Reset is asynchronous and active-low: clk, rst_n.
- Reset values:
  - out_valid=0, data_out=0, lost_out=0, busy=0.
  - All stage valid, data, ctrl and lost registers are 0.
  - in_ready=1 once rst_n is high.
- Pipeline structure:
  - SHW register stages. Stage k conditionally shifts by 2^k when shift_amt[k]=1.
  - dir, mode and the remaining shift_amt bits travel with the data through every stage.
- Stall and handshake:
  - Global stall: adv = out_ready | ~out_valid. Every stage loads only when adv=1.
  - in_ready = adv, combinational.
  - A beat is accepted on a rising edge with in_valid & in_ready.
  - If in_valid=0 on an advancing edge, stage 0 loads valid=0; bubbles propagate.
- Latency:
  - Exactly SHW cycles from acceptance to out_valid, with no stall. For WIDTH=8 that is 3 cycles.
  - Throughput is 1 beat per cycle. Beats are delivered in order.
- Output stability: while out_valid=1 and out_ready=0, data_out and lost_out hold stable and nothing is lost or duplicated.
- Mode semantics:
  - Logical: fill with 0.
  - Arithmetic right: fill with data_in[WIDTH-1].
  - Arithmetic left: identical to logical left.
  - Rotate: bits wrap around; lost_out=0.
  - Reserved mode 11: treated as logical.
- lost_out: OR over all bits shifted beyond the boundary, accumulated stage by stage. For arithmetic right it still reports the dropped LSBs.
- shift_amt=0: data passes unchanged after SHW cycles, lost_out=0.
- Reset mid-operation: all in-flight beats are discarded and no out_valid is produced for them after release.
- Outputs are registered (data_out, lost_out, out_valid come from the last stage). in_ready and busy are combinational from registers plus out_ready.

Decomposition:
- Package shifter_pkg:
  - typedef enum logic [1:0] shift_mode_e {SH_LOG, SH_ARI, SH_ROT, SH_RSV}.
  - Typedef of the per-stage ctrl struct (dir, mode, shift_amt).
  - Localparam rule that WIDTH is a power of 2.
- Sub-module shift_stage:
  - Parameters WIDTH and DIST.
  - Combinational conditional shift by DIST plus the lost bit.
  - Instantiated SHW times in a generate loop. barrel_shifter_pipe owns all registers and handshake.

Test Plan:
All scenarios use WIDTH=8.
1. Reset: hold rst_n=0 across 3 edges -> out_valid=0, data_out=8'h00, lost_out=0, busy=0. After release, in_ready=1.
2. Logical left: data_in=8'hB5, amt=3, dir=0, mode=00 -> out_valid 3 cycles later, data_out=8'hA8, lost_out=1.
3. Arithmetic right: data_in=8'h90, amt=2, dir=1, mode=01 -> data_out=8'hE4, lost_out=0. Then 8'h93 with the same settings -> 8'hE4, lost_out=1.
4. Rotate and zero shift:
   - 8'h81, amt=1, dir=1, mode=10 -> 8'hC0, lost_out=0.
   - 8'h5A, amt=0 -> 8'h5A, lost_out=0.
5. Backpressure: stream 5 back-to-back beats while holding out_ready=0 for 6 cycles after the first out_valid -> in_ready=0 while stalled, data_out stable, then all 5 results emerge in order on consecutive cycles.
6. Reset mid-flight: accept 2 beats, pull rst_n low 1 cycle later for 1 cycle -> no out_valid for either beat, busy=0 after release.
